// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mux2_dp.sv
// Shared 2:1 datapath mux: routes the granted requester's beat downstream.
// When nothing is granted (en = 0) the forwarded beat is forced to zero.
module mux2_dp #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic             en,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             last0,
  input  logic             last1,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  // Select the beat and its last flag, gated by grant ownership.
  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    if (en) begin
      out_data = sel ? data1 : data0;
      out_last = sel ? last1 : last0;
    end
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter owning the select line of a shared 2:1 datapath mux.
// Grants whole bursts; a grant ends on a transferred last beat or when the
// owner drops its request, always followed by one IDLE bubble cycle.
// Optional hold watchdog compiled in with ARB_WATCHDOG_EN (adds wdog_fire).
//
//   state | meaning
//   IDLE  | no owner; arbitrate using the priority pointer
//   OWN0  | requester 0 owns the mux (sel = 0)
//   OWN1  | requester 1 owns the mux (sel = 1)
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             last0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic             last1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
`ifdef ARB_WATCHDOG_EN
  ,
  output logic             wdog_fire
`endif
);

  state_t state;
  state_t state_nxt;
  logic   ptr;
  logic   hold_expire;

  // Grant and select are straight decodes of the state register.
  assign gnt0 = (state == OWN0);
  assign gnt1 = (state == OWN1);
  assign sel  = gnt1;

  assign ack0      = gnt0 & req0 & out_ready;
  assign ack1      = gnt1 & req1 & out_ready;
  assign out_valid = (gnt0 & req0) | (gnt1 & req1);

  mux2_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .sel     (sel),
    .en      (gnt0 | gnt1),
    .data0   (data0),
    .data1   (data1),
    .last0   (last0),
    .last1   (last1),
    .out_data(out_data),
    .out_last(out_last)
  );

`ifdef ARB_WATCHDOG_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt;

  // Expire on the MAX_HOLD-th grant cycle, so the grant lasts MAX_HOLD cycles.
  assign hold_expire = (state != IDLE) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // Hold counter runs while a grant is held and clears whenever IDLE is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      wdog_fire <= 1'b0;
    end else begin
      wdog_fire <= hold_expire;
      if (state_nxt == IDLE) begin
        hold_cnt <= '0;
      end else if (state != IDLE) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign hold_expire = 1'b0;

  // MAX_HOLD only sizes the watchdog; this empty guard keeps it referenced.
  if (MAX_HOLD < 1) begin : g_max_hold_unused
  end
`endif

  // Next-state arbitration and burst release.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_nxt = (ptr == REQ1) ? OWN1 : OWN0;
        end else if (req0) begin
          state_nxt = OWN0;
        end else if (req1) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!req0 || (ack0 && last0) || hold_expire) begin
          state_nxt = IDLE;
        end
      end
      OWN1: begin
        if (!req1 || (ack1 && last1) || hold_expire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and priority pointer; pointer flips to the other side on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= REQ0;
    end else begin
      state <= state_nxt;
      if (state == OWN0 && state_nxt == IDLE) begin
        ptr <= REQ1;
      end else if (state == OWN1 && state_nxt == IDLE) begin
        ptr <= REQ0;
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed self-checking bench for mux2_rr_arbiter (default build).
module tb_mux2_rr_arbiter;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             req0, req1, last0, last1, out_ready;
  logic [WIDTH-1:0] data0, data1;
  logic             gnt0, gnt1, ack0, ack1, sel, out_valid, out_last;
  logic [WIDTH-1:0] out_data;
`ifdef ARB_WATCHDOG_EN
  logic             wdog_fire;
`endif

  int total = 0;
  int bad   = 0;

  mux2_rr_arbiter #(
    .WIDTH(WIDTH),
    .MAX_HOLD(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .data0    (data0),
    .last0    (last0),
    .req1     (req1),
    .data1    (data1),
    .last1    (last1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .ack0     (ack0),
    .ack1     (ack1),
    .sel      (sel),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready)
`ifdef ARB_WATCHDOG_EN
    ,
    .wdog_fire(wdog_fire)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Contention pattern, one entry per cycle starting with the first grant.
  logic exp_g0 [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic exp_g1 [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
    data0 = '0; data1 = '0; out_ready = 1'b0;

    // Reset values
    #3;
    chk("rst_gnt0", gnt0, 1'b0);
    chk("rst_gnt1", gnt1, 1'b0);
    chk("rst_sel", sel, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_last", out_last, 1'b0);
    chk("rst_ack0", ack0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Single requester, one-beat burst
    tick();
    req0 = 1'b1; data0 = 8'hA5; last0 = 1'b1; out_ready = 1'b1;
    #1;
    chk("t1_idle_gnt0", gnt0, 1'b0);
    chk("t1_idle_ack0", ack0, 1'b0);
    tick();
    chk("t1_gnt0", gnt0, 1'b1);
    chk("t1_sel", sel, 1'b0);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 8'hA5);
    chk("t1_last", out_last, 1'b1);
    chk("t1_ack0", ack0, 1'b1);
    chk("t1_ack1", ack1, 1'b0);
    tick();
    chk("t1_rel_gnt0", gnt0, 1'b0);
    chk("t1_rel_ack0", ack0, 1'b0);
    chk("t1_rel_data", out_data, 8'h00);
    req0 = 1'b0; last0 = 1'b0;
    tick();
    chk("t1_stay_idle", gnt0, 1'b0);

    // Reset so the pointer favours requester 0 again
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Contention with 1-beat bursts
    tick();
    req0 = 1'b1; data0 = 8'h11; last0 = 1'b1;
    req1 = 1'b1; data1 = 8'h22; last1 = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t2_start_gnt0", gnt0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t2_gnt0_c%0d", i), gnt0, exp_g0[i]);
      chk($sformatf("t2_gnt1_c%0d", i), gnt1, exp_g1[i]);
      chk($sformatf("t2_sel_c%0d", i), sel, exp_g1[i]);
      chk($sformatf("t2_data_c%0d", i), out_data,
          exp_g0[i] ? 32'h11 : (exp_g1[i] ? 32'h22 : 32'h0));
    end
    req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
    tick();

    // Multi-beat burst on requester 1 with a two-cycle stall
    req1 = 1'b1; data1 = 8'h01; last1 = 1'b0; out_ready = 1'b1;
    tick();
    chk("t3_gnt1", gnt1, 1'b1);
    chk("t3_sel", sel, 1'b1);
    chk("t3_b1_data", out_data, 8'h01);
    chk("t3_b1_ack", ack1, 1'b1);
    tick();
    data1 = 8'h02; out_ready = 1'b0;
    #1;
    chk("t3_stall1_ack", ack1, 1'b0);
    chk("t3_stall1_gnt", gnt1, 1'b1);
    chk("t3_stall1_data", out_data, 8'h02);
    chk("t3_stall1_valid", out_valid, 1'b1);
    tick();
    chk("t3_stall2_ack", ack1, 1'b0);
    chk("t3_stall2_gnt", gnt1, 1'b1);
    tick();
    chk("t3_stall3_gnt", gnt1, 1'b1);
    out_ready = 1'b1;
    #1;
    chk("t3_b2_ack", ack1, 1'b1);
    chk("t3_b2_data", out_data, 8'h02);
    tick();
    data1 = 8'h03; last1 = 1'b1;
    #1;
    chk("t3_b3_ack", ack1, 1'b1);
    chk("t3_b3_data", out_data, 8'h03);
    chk("t3_b3_last", out_last, 1'b1);
    tick();
    chk("t3_rel_gnt1", gnt1, 1'b0);
    chk("t3_rel_ack1", ack1, 1'b0);
    req1 = 1'b0; last1 = 1'b0;

    // Abort: requester 0 drops after one of four beats, requester 1 waiting
    req0 = 1'b1; data0 = 8'hA0; last0 = 1'b0;
    req1 = 1'b1; data1 = 8'hB0; last1 = 1'b1;
    tick();
    chk("t4_gnt0", gnt0, 1'b1);
    chk("t4_gnt1", gnt1, 1'b0);
    chk("t4_b1_data", out_data, 8'hA0);
    chk("t4_b1_ack", ack0, 1'b1);
    tick();
    req0 = 1'b0;
    #1;
    chk("t4_drop_gnt0", gnt0, 1'b1);
    chk("t4_drop_ack0", ack0, 1'b0);
    chk("t4_drop_valid", out_valid, 1'b0);
    tick();
    chk("t4_bubble_gnt0", gnt0, 1'b0);
    chk("t4_bubble_gnt1", gnt1, 1'b0);
    tick();
    chk("t4_next_gnt1", gnt1, 1'b1);
    chk("t4_next_data", out_data, 8'hB0);
    chk("t4_next_ack1", ack1, 1'b1);
    tick();
    chk("t4_rel_gnt1", gnt1, 1'b0);
    req1 = 1'b0; last1 = 1'b0;

    // Asynchronous reset in the middle of a requester 1 burst
    req1 = 1'b1; data1 = 8'hC3; last1 = 1'b0;
    tick();
    chk("t5_gnt1", gnt1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_gnt1", gnt1, 1'b0);
    chk("t5_rst_sel", sel, 1'b0);
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_ack1", ack1, 1'b0);
    chk("t5_rst_data", out_data, 8'h00);
    req0 = 1'b1; data0 = 8'h5A; last0 = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_post_idle", gnt0 | gnt1, 1'b0);
    tick();
    chk("t5_first_gnt0", gnt0, 1'b1);
    chk("t5_first_gnt1", gnt1, 1'b0);
    chk("t5_first_data", out_data, 8'h5A);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
